// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM responder: FSM encoding,
// wait-state counter width and byte-lane helpers.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Wide enough for WAIT_CYCLES up to 15
  localparam int CNT_W  = 4;
  localparam int BYTE_W = 8;

  function automatic int lanes(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/wb_ram_bytearray.sv
// Byte-enabled storage array: synchronous masked write, registered read
// port whose output holds until the next read strobe.
module wb_ram_bytearray
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int NL        = lanes(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [NL-1:0]         sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  always_comb begin
    word_d = mem_q[idx];
    for (int l = 0; l < NL; l++) begin
      if (sel[l]) word_d[l*BYTE_W +: BYTE_W] = wdata[l*BYTE_W +: BYTE_W];
    end
    rdata_d = re ? mem_q[idx] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) mem_q[idx] <= word_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic slave backed by a byte-lane RAM with configurable wait
// states. Define WB_RAM_ERR_EN to add wb_err_o and out-of-range checking.
module wb_ram_responder
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o
`ifdef WB_RAM_ERR_EN
  ,
  output logic                    wb_err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NL    = lanes(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [NL-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  req, in_idle, finish, oor;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic                  cur_we;
  logic [NL-1:0]         cur_sel;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic                  ram_we, ram_re;

  // With zero wait states the request completes on the sampling edge, so the
  // RAM must see the live bus instead of the latched copy.
  assign req     = wb_cyc_i & wb_stb_i;
  assign in_idle = (state_q == ST_IDLE);
  assign cur_adr = in_idle ? wb_adr_i : adr_q;
  assign cur_we  = in_idle ? wb_we_i  : we_q;
  assign cur_sel = in_idle ? wb_sel_i : sel_q;
  assign cur_dat = in_idle ? wb_dat_i : dat_q;
  assign oor     = (cur_adr >> IDX_W) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !ack_q) begin
          adr_d = wb_adr_i;
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          cnt_d = '0;
          if (WAIT_CYCLES == 0) finish = 1'b1;
          else state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d = ST_ACK;
      cnt_d   = '0;
      if (ERR_EN && oor) begin
        err_d = 1'b1;
      end else begin
        ack_d  = 1'b1;
        ram_we = cur_we;
        ram_re = !cur_we;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wb_ram_bytearray #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (cur_adr[IDX_W-1:0]),
    .sel   (cur_sel),
    .wdata (cur_dat),
    .rdata (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
`ifdef WB_RAM_ERR_EN
  assign wb_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
